// File: rtl/ah_arith_pkg.sv
// Shared arithmetic-pipeline definitions for the multiplier and divider revisions.
// Holds default geometry, the geometry legality check and the common stage record.
package ah_arith_pkg;

  localparam int AH_WIDTH  = 32;
  localparam int AH_STAGES = 8;

  function automatic bit ah_geometry_ok(input int width, input int stages);
    return (width >= 2) && (stages >= 1) && ((width % stages) == 0);
  endfunction

  // Guarded so an illegal STAGES still elaborates far enough to hit the fatal check.
  function automatic int ah_bps(input int width, input int stages);
    return (stages > 0) ? (width / stages) : 1;
  endfunction

  localparam int AH_BPS = ah_bps(AH_WIDTH, AH_STAGES);

  typedef struct packed {
    logic                  valid;
    logic                  neg;
    logic                  zero;
    logic [AH_WIDTH-1:0]   a_mag;
    logic [AH_WIDTH-1:0]   b_rem;
    logic [2*AH_WIDTH-1:0] acc;
  } ah_stage_t;

endpackage

// File: rtl/ah_mul_pipelined_if.sv
// Streaming start/data_valid handshake shared by the pipelined multiplier and divider.
interface ah_mul_pipelined_if
  import ah_arith_pkg::*;
#(
  parameter int WIDTH = AH_WIDTH
);
  logic               start;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic [2*WIDTH-1:0] product;
  logic               data_valid;
  logic               zero_operand;

  modport master (
    output start, multiplicand, multiplier,
    input  product, data_valid, zero_operand
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output product, data_valid, zero_operand
  );
endinterface

// File: rtl/ah_mul_stage.sv
// One accumulation stage: folds the lowest BPS remaining multiplier bits times |A|
// into the unsigned accumulator and passes the rest of the record forward.
module ah_mul_stage
  import ah_arith_pkg::*;
#(
  parameter int  WIDTH     = AH_WIDTH,
  parameter int  BPS       = AH_BPS,
  parameter int  STAGE_IDX = 1,
  parameter type stage_t   = ah_stage_t
) (
  input  logic   clk,
  input  logic   rst_n,
  input  stage_t d,
  output stage_t q
);

  localparam int SHIFT = (STAGE_IDX - 1) * BPS;

  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] chunk_ext;
  logic [2*WIDTH-1:0] partial;

  // b_rem is pre-shifted each stage, so the chunk is always its low BPS bits.
  always_comb begin
    a_ext     = {{WIDTH{1'b0}}, d.a_mag};
    chunk_ext = {{(2*WIDTH-BPS){1'b0}}, d.b_rem[BPS-1:0]};
    partial   = (a_ext * chunk_ext) << SHIFT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      q.valid <= d.valid;
      q.neg   <= d.neg;
      q.zero  <= d.zero;
      q.a_mag <= d.a_mag;
      q.b_rem <= d.b_rem >> BPS;
      q.acc   <= d.acc + partial;
    end
  end

endmodule

// File: rtl/ah_mul_pipelined.sv
// Pipelined signed WIDTH x WIDTH -> 2*WIDTH multiplier: input stage, STAGES
// accumulation stages and a sign-restoring output stage; no stalls.
module ah_mul_pipelined
  import ah_arith_pkg::*;
#(
  parameter int WIDTH  = AH_WIDTH,
  parameter int STAGES = AH_STAGES
) (
  input logic             clk,
  input logic             rst_n,
  ah_mul_pipelined_if.slave bus
);

  localparam int BPS = ah_bps(WIDTH, STAGES);

  if (!ah_geometry_ok(WIDTH, STAGES)) begin : g_bad_geometry
    $fatal(1, "ah_mul_pipelined: WIDTH must be >= 2 and a multiple of STAGES");
  end

  // Same layout as ah_stage_t, sized for this instance.
  typedef struct packed {
    logic               valid;
    logic               neg;
    logic               zero;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_rem;
    logic [2*WIDTH-1:0] acc;
  } stage_t;

  stage_t             s0;
  stage_t             chain [STAGES+1];
  logic [WIDTH-1:0]   a_mag_in;
  logic [WIDTH-1:0]   b_mag_in;
  logic [2*WIDTH-1:0] product_q;
  logic               data_valid_q;
  logic               zero_operand_q;

  // -2^(WIDTH-1) negates to itself, which read unsigned is exactly its magnitude.
  always_comb begin
    a_mag_in = bus.multiplicand[WIDTH-1] ? (~bus.multiplicand + WIDTH'(1)) : bus.multiplicand;
    b_mag_in = bus.multiplier[WIDTH-1]   ? (~bus.multiplier + WIDTH'(1))   : bus.multiplier;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0 <= '0;
    end else begin
      s0.valid <= bus.start;
      s0.neg   <= bus.multiplicand[WIDTH-1] ^ bus.multiplier[WIDTH-1];
      s0.zero  <= (bus.multiplicand == '0) || (bus.multiplier == '0);
      s0.a_mag <= a_mag_in;
      s0.b_rem <= b_mag_in;
      s0.acc   <= '0;
    end
  end

  assign chain[0] = s0;

  for (genvar k = 1; k <= STAGES; k++) begin : g_stage
    ah_mul_stage #(
      .WIDTH    (WIDTH),
      .BPS      (BPS),
      .STAGE_IDX(k),
      .stage_t  (stage_t)
    ) u_stage (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (chain[k-1]),
      .q    (chain[k])
    );
  end

  // Negating a zero accumulator yields zero, so a zero operand never produces -0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product_q      <= '0;
      data_valid_q   <= 1'b0;
      zero_operand_q <= 1'b0;
    end else begin
      product_q      <= chain[STAGES].neg ? (~chain[STAGES].acc + (2*WIDTH)'(1))
                                          : chain[STAGES].acc;
      data_valid_q   <= chain[STAGES].valid;
      zero_operand_q <= chain[STAGES].zero;
    end
  end

  assign bus.product      = product_q;
  assign bus.data_valid   = data_valid_q;
  assign bus.zero_operand = zero_operand_q;

endmodule

// File: tb/tb_ah_mul_pipelined.sv
// Scoreboard bench for ah_mul_pipelined: stimulus pushes expected results with
// their due cycle; a negedge monitor pops and compares whenever data_valid is seen.
module tb_ah_mul_pipelined;

  localparam int W   = 32;
  localparam int LAT = 10;

  typedef struct {
    logic [63:0] prod;
    logic        zero;
    int          due;
    string       tag;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t sb_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ah_mul_pipelined_if #(.WIDTH(W)) mif ();

  ah_mul_pipelined #(.WIDTH(W), .STAGES(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (mif)
  );

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    sa = $signed({{32{a[31]}}, a});
    sb = $signed({{32{b[31]}}, b});
    return 64'(sa * sb);
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      mif.start        = 1'b0;
      mif.multiplicand = 32'd5;
      mif.multiplier   = -32'sd7;
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] prod, input logic zero, input string tag);
    exp_t e;
    @(negedge clk);
    mif.start        = 1'b1;
    mif.multiplicand = a;
    mif.multiplier   = b;
    e.prod = prod;
    e.zero = zero;
    e.due  = cyc + LAT;
    e.tag  = tag;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * LAT && sb_q.size() != 0; i++) @(negedge clk);
    check_int("drain_pending", sb_q.size(), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mif.data_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid: data_valid=1 at cycle %0d, required no output", cyc);
      end else begin
        e = sb_q.pop_front();
        check64({e.tag, "_product"}, mif.product, e.prod);
        check64({e.tag, "_zero"}, {63'd0, mif.zero_operand}, {63'd0, e.zero});
        check_int({e.tag, "_arrival"}, cyc, e.due);
      end
    end else if (sb_q.size() != 0 && sb_q[0].due < cyc) begin
      e = sb_q.pop_front();
      check_int({e.tag, "_missing"}, cyc, e.due);
    end
  end

  initial begin
    logic [31:0] ra, rb;
    mif.start        = 1'b0;
    mif.multiplicand = 32'd5;
    mif.multiplier   = -32'sd7;

    #12;
    check64("reset_product", mif.product, 64'd0);
    check64("reset_valid", {63'd0, mif.data_valid}, 64'd0);
    check64("reset_zero", {63'd0, mif.zero_operand}, 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    idle(3);

    issue(32'd7, 32'd6, 64'd42, 1'b0, "basic");
    idle(2);
    issue(-32'sd3, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0, "neg_pos");
    issue(-32'sd3, -32'sd5, 64'd15, 1'b0, "neg_neg");
    issue(32'd3, -32'sd5, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0, "pos_neg");
    issue(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0, "min_min");
    issue(32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000, 1'b0, "min_max");
    issue(32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 1'b0, "max_max");
    issue(32'd0, -32'sd9, 64'd0, 1'b1, "zero_a");
    issue(-32'sd1, 32'd0, 64'd0, 1'b1, "zero_b");
    idle(1);
    drain();

    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i == 5) ra = 32'd0;
      issue(ra, rb, model(ra, rb), (ra == 0) || (rb == 0), $sformatf("stream%0d", i));
    end
    idle(3);
    for (int i = 20; i < 25; i++) begin
      ra = $urandom;
      rb = $urandom;
      issue(ra, rb, model(ra, rb), (ra == 0) || (rb == 0), $sformatf("stream%0d", i));
    end
    idle(1);
    drain();

    issue(32'd2, 32'd3, 64'd6, 1'b0, "flight0");
    issue(32'd4, 32'd5, 64'd20, 1'b0, "flight1");
    issue(32'd6, 32'd7, 64'd42, 1'b0, "flight2");
    issue(32'd8, 32'd9, 64'd72, 1'b0, "flight3");
    idle(2);
    #3 rst_n = 1'b0;
    sb_q.delete();
    #1;
    check64("midreset_product", mif.product, 64'd0);
    check64("midreset_valid", {63'd0, mif.data_valid}, 64'd0);
    check64("midreset_zero", {63'd0, mif.zero_operand}, 64'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    idle(2 * LAT);
    issue(32'd11, -32'sd2, 64'hFFFF_FFFF_FFFF_FFEA, 1'b0, "after_reset");
    idle(1);
    drain();
    idle(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
